// File: rtl/producer_pkg.sv
// Shared types and constants for the stall-aware dual-lane producer.
package producer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } lane_state_t;

  localparam logic [3:0]  LANE1_TAG = 4'h1;
  localparam logic [3:0]  LANE2_TAG = 4'h2;
  localparam int unsigned SEQ_W     = 28;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 16;

endpackage

// File: rtl/producer_lane.sv
// One producer lane: tagged sequence generator with stall hold and periodic flush.
module producer_lane
  import producer_pkg::*;
#(
  parameter logic [3:0]  TAG          = LANE1_TAG,
  parameter int unsigned NUM_ITEMS    = 64,
  parameter int unsigned FLUSH_PERIOD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              flush,
  output logic [CNT_W-1:0]  accepted,
  output logic              is_done
);

  localparam logic [CNT_W-1:0] LAST_COUNT = NUM_ITEMS[CNT_W-1:0];
  localparam int unsigned      FP_SAFE    = (FLUSH_PERIOD == 0) ? 1 : FLUSH_PERIOD;
  localparam logic [CNT_W-1:0] FP_COUNT   = FP_SAFE[CNT_W-1:0];
  localparam bit               FLUSH_EN   = (FLUSH_PERIOD != 0);

  lane_state_t       state, state_nx;
  logic [SEQ_W-1:0]  seq, seq_nx;
  logic [CNT_W-1:0]  acc_nx, acc_inc;
  logic [DATA_W-1:0] data_nx;
  logic              valid_nx, flush_nx, done_nx;

  always_comb begin
    state_nx = state;
    seq_nx   = seq;
    acc_nx   = accepted;
    acc_inc  = accepted + 16'd1;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SEND;
          seq_nx   = '0;
        end
      end
      SEND: begin
        if (!stall) begin
          acc_nx = acc_inc;
          seq_nx = seq + 28'd1;
          if (acc_inc == LAST_COUNT)
            state_nx = DONE;
          else if (FLUSH_EN && ((acc_inc % FP_COUNT) == '0))
            state_nx = FLUSH;
        end
      end
      FLUSH:   state_nx = SEND;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the lane as flops.
    valid_nx = (state_nx == SEND);
    flush_nx = (state_nx == FLUSH);
    done_nx  = (state_nx == DONE);
    data_nx  = (state_nx == SEND || state_nx == FLUSH) ? {TAG, seq_nx} : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      seq      <= '0;
      accepted <= '0;
      data     <= '0;
      valid    <= 1'b0;
      flush    <= 1'b0;
      is_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      seq      <= seq_nx;
      accepted <= acc_nx;
      data     <= data_nx;
      valid    <= valid_nx;
      flush    <= flush_nx;
      is_done  <= done_nx;
    end
  end

endmodule

// File: rtl/stall_aware_producer.sv
// Dual-lane producer honouring per-lane stalls; wires two independent lanes.
module stall_aware_producer
  import producer_pkg::*;
#(
  parameter int unsigned NUM_ITEMS    = 64,
  parameter int unsigned FLUSH_PERIOD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall_1,
  input  logic        stall_2,
  output logic [31:0] pipeline1_inputs,
  output logic [31:0] pipeline2_inputs,
  output logic [1:0]  in_valid,
  output logic        flush_1,
  output logic        flush_2,
  output logic [15:0] accepted_1,
  output logic [15:0] accepted_2,
  output logic        done
);

  logic valid_1, valid_2, done_1, done_2;

  producer_lane #(
    .TAG          (LANE1_TAG),
    .NUM_ITEMS    (NUM_ITEMS),
    .FLUSH_PERIOD (FLUSH_PERIOD)
  ) u_lane1 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stall    (stall_1),
    .data     (pipeline1_inputs),
    .valid    (valid_1),
    .flush    (flush_1),
    .accepted (accepted_1),
    .is_done  (done_1)
  );

  producer_lane #(
    .TAG          (LANE2_TAG),
    .NUM_ITEMS    (NUM_ITEMS),
    .FLUSH_PERIOD (FLUSH_PERIOD)
  ) u_lane2 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stall    (stall_2),
    .data     (pipeline2_inputs),
    .valid    (valid_2),
    .flush    (flush_2),
    .accepted (accepted_2),
    .is_done  (done_2)
  );

  assign in_valid = {valid_2, valid_1};
  assign done     = done_1 & done_2;

endmodule

// File: tb/tb_stall_aware_producer.sv
// Directed bench with a data scoreboard for stall_aware_producer.
module tb_stall_aware_producer;

  logic clk = 1'b0;
  logic reset, start, a_st1, a_st2, b_st1, b_st2;

  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic [1:0]  a_valid, b_valid;
  logic        a_fl1, a_fl2, b_fl1, b_fl2, a_done, b_done;
  logic [15:0] a_acc1, a_acc2, b_acc1, b_acc2;

  stall_aware_producer #(.NUM_ITEMS(8), .FLUSH_PERIOD(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stall_1(a_st1), .stall_2(a_st2),
    .pipeline1_inputs(a_d1), .pipeline2_inputs(a_d2), .in_valid(a_valid),
    .flush_1(a_fl1), .flush_2(a_fl2), .accepted_1(a_acc1), .accepted_2(a_acc2),
    .done(a_done)
  );

  stall_aware_producer #(.NUM_ITEMS(8), .FLUSH_PERIOD(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stall_1(b_st1), .stall_2(b_st2),
    .pipeline1_inputs(b_d1), .pipeline2_inputs(b_d2), .in_valid(b_valid),
    .flush_1(b_fl1), .flush_2(b_fl2), .accepted_1(b_acc1), .accepted_2(b_acc2),
    .done(b_done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  bit          mon_en = 1'b0;
  int unsigned fl_a1 = 0, fl_a2 = 0, fl_b = 0;
  logic [31:0] sbq [4][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Index 0/1 = dut_a lanes 1/2, index 2/3 = dut_b lanes 1/2.
  task automatic mon_lane(input int unsigned idx, input string tag, input logic v,
                          input logic st, input logic [31:0] d);
    if (v) begin
      chk({tag, "_avail"}, 32'(sbq[idx].size() != 0), 32'd1);
      if (sbq[idx].size() != 0) begin
        chk(tag, d, sbq[idx][0]);
        if (!st) void'(sbq[idx].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_lane(0, "a1_data", a_valid[0], a_st1, a_d1);
      mon_lane(1, "a2_data", a_valid[1], a_st2, a_d2);
      mon_lane(2, "b1_data", b_valid[0], b_st1, b_d1);
      mon_lane(3, "b2_data", b_valid[1], b_st2, b_d2);
      if (a_fl1) fl_a1++;
      if (a_fl2) fl_a2++;
      if (b_fl1 || b_fl2) fl_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic clear_sb();
    for (int unsigned i = 0; i < 4; i++) sbq[i].delete();
    fl_a1 = 0;
    fl_a2 = 0;
    fl_b  = 0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    skip(2);
    reset  = 1'b0;
    clear_sb();
    mon_en = 1'b1;
  endtask

  task automatic launch();
    for (int unsigned i = 0; i < 8; i++) begin
      sbq[0].push_back({4'h1, 28'(i)});
      sbq[1].push_back({4'h2, 28'(i)});
      sbq[2].push_back({4'h1, 28'(i)});
      sbq[3].push_back({4'h2, 28'(i)});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (!a_done && n < budget) begin
      tick();
      n++;
    end
    chk("done_within_budget", 32'(a_done), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(a_valid), 32'd0);
    chk({tag, "_d1"},    a_d1, 32'd0);
    chk({tag, "_d2"},    a_d2, 32'd0);
    chk({tag, "_flush"}, 32'({a_fl2, a_fl1}), 32'd0);
    chk({tag, "_acc1"},  32'(a_acc1), 32'd0);
    chk({tag, "_acc2"},  32'(a_acc2), 32'd0);
    chk({tag, "_done"},  32'(a_done), 32'd0);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    a_st1 = 1'b0; a_st2 = 1'b0; b_st1 = 1'b0; b_st2 = 1'b0;
    skip(2);
    chk_idle_outputs("rst");
    chk("rst_b_valid", 32'(b_valid), 32'd0);

    // start together with reset must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    tick();
    chk("start_in_reset_valid", 32'(a_valid), 32'd0);
    mon_en = 1'b1;

    // Test 1: no stall, flush every 4 on dut_a, no flushing on dut_b
    launch();
    chk("t1_c1_valid", 32'(a_valid), 32'd3);
    chk("t1_c1_d1", a_d1, 32'h1000_0000);
    chk("t1_c1_d2", a_d2, 32'h2000_0000);
    skip(3);
    chk("t1_c4_d1", a_d1, 32'h1000_0003);
    skip(1);
    chk("t1_c5_fl1", 32'(a_fl1), 32'd1);
    chk("t1_c5_fl2", 32'(a_fl2), 32'd1);
    chk("t1_c5_valid", 32'(a_valid), 32'd0);
    chk("t1_c5_d1_next", a_d1, 32'h1000_0004);
    skip(1);
    chk("t1_c6_fl1", 32'(a_fl1), 32'd0);
    chk("t1_c6_valid", 32'(a_valid), 32'd3);
    skip(3);
    chk("t1_c9_d1", a_d1, 32'h1000_0007);
    chk("t1_c9_a_done", 32'(a_done), 32'd0);
    chk("t1_c9_b_done", 32'(b_done), 32'd1);
    chk("t1_c9_b_acc1", 32'(b_acc1), 32'd8);
    skip(1);
    chk("t1_c10_a_done", 32'(a_done), 32'd1);
    chk("t1_c10_acc1", 32'(a_acc1), 32'd8);
    chk("t1_c10_acc2", 32'(a_acc2), 32'd8);
    chk("t1_c10_fl1", 32'(a_fl1), 32'd0);
    chk("t1_c10_d1", a_d1, 32'd0);
    skip(2);
    chk("t1_fl_a1_count", 32'(fl_a1), 32'd1);
    chk("t1_fl_a2_count", 32'(fl_a2), 32'd1);
    chk("t1_fl_b_count", 32'(fl_b), 32'd0);
    chk("t1_sb_empty", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);

    // Test 2: stall_1 for three cycles while item 2 is valid
    do_reset();
    launch();
    skip(2);
    chk("t2_c3_d1", a_d1, 32'h1000_0002);
    a_st1 = 1'b1;
    skip(1);
    chk("t2_c4_d1_hold", a_d1, 32'h1000_0002);
    chk("t2_c4_v1_hold", 32'(a_valid[0]), 32'd1);
    skip(1);
    chk("t2_c5_d1_hold", a_d1, 32'h1000_0002);
    chk("t2_c5_fl2_unaffected", 32'(a_fl2), 32'd1);
    chk("t2_c5_fl1", 32'(a_fl1), 32'd0);
    skip(1);
    chk("t2_c6_d1_hold", a_d1, 32'h1000_0002);
    a_st1 = 1'b0;
    skip(1);
    chk("t2_c7_d1", a_d1, 32'h1000_0003);
    skip(3);
    chk("t2_c10_acc2", 32'(a_acc2), 32'd8);
    chk("t2_c10_done", 32'(a_done), 32'd0);
    skip(2);
    chk("t2_c12_done", 32'(a_done), 32'd0);
    skip(1);
    chk("t2_c13_done", 32'(a_done), 32'd1);
    chk("t2_c13_acc1", 32'(a_acc1), 32'd8);
    skip(1);
    chk("t2_fl_a1_count", 32'(fl_a1), 32'd1);

    // Test 3: stall_1 high across the flush cycle
    do_reset();
    launch();
    skip(4);
    chk("t3_c5_fl1", 32'(a_fl1), 32'd1);
    a_st1 = 1'b1;
    skip(1);
    chk("t3_c6_fl1", 32'(a_fl1), 32'd0);
    chk("t3_c6_v1", 32'(a_valid[0]), 32'd1);
    chk("t3_c6_d1", a_d1, 32'h1000_0004);
    skip(1);
    chk("t3_c7_d1_hold", a_d1, 32'h1000_0004);
    a_st1 = 1'b0;
    wait_done(30);
    chk("t3_fl_a1_count", 32'(fl_a1), 32'd1);
    chk("t3_acc1", 32'(a_acc1), 32'd8);

    // Test 4: start during SEND is ignored; reset mid-operation then restart
    do_reset();
    launch();
    skip(1);
    start = 1'b1;
    skip(1);
    start = 1'b0;
    chk("t4_c3_acc1", 32'(a_acc1), 32'd2);
    chk("t4_c3_d1", a_d1, 32'h1000_0002);
    skip(4);
    chk("t4_c7_acc1", 32'(a_acc1), 32'd5);
    mon_en = 1'b0;
    reset  = 1'b1;
    skip(1);
    reset  = 1'b0;
    chk_idle_outputs("t4_rst");
    clear_sb();
    mon_en = 1'b1;
    skip(1);
    chk("t4_no_autostart", 32'(a_valid), 32'd0);
    launch();
    chk("t4_restart_d1", a_d1, 32'h1000_0000);
    chk("t4_restart_acc1", 32'(a_acc1), 32'd0);
    wait_done(30);
    chk("t4_final_acc1", 32'(a_acc1), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
